// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, PCSrc codes, stall lengths.
// The MULDIV state and the wider counter exist only when HAZARD_MULDIV_EN is defined.
package hazard_ctrl_pkg;

`ifdef HAZARD_MULDIV_EN
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STALL     = 2'd1,
    ST_IRQ_FLUSH = 2'd2,
    ST_MULDIV    = 2'd3
  } state_e;

  localparam int CNT_W = 6;
`else
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STALL     = 2'd1,
    ST_IRQ_FLUSH = 2'd2
  } state_e;

  localparam int CNT_W = 2;
`endif

  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_BR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;

  localparam int unsigned MULDIV_LATENCY_DEF = 32;

  // jr whose Rs comes from a load still in EX waits for the load to clear MEM.
  localparam int unsigned JR_EX_STALL_CYCLES = 2;

endpackage

// File: rtl/hazard_ctrl_stall_counter.sv
// Loadable down-counter shared by the STALL and MULDIV states.
// zero_o reports that the count will be zero after this cycle's load/decrement.
module stall_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / jr stalls, control-transfer flush, interrupt flush.
// Define HAZARD_MULDIV_EN to add the multi-cycle MULDIV stall state.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = MULDIV_LATENCY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_InstRt,
  input  logic       EX_MEM_MemRead,
  input  logic [4:0] EX_MEM_RegWriteAddr,
  input  logic [4:0] IF_ID_InstRs,
  input  logic [4:0] IF_ID_InstRt,
  input  logic [2:0] ID_PCSrc,
  input  logic       IRQ,
  input  logic       MulDiv_Start,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       EX_MEM_Flush,
  output logic       IRQ_Ack,
  output logic       Busy,
  output state_e     dbg_state_o
);

  state_e            state_q, state_d;
  logic              irq_block_q, irq_block_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              stall;
  logic              load_use, jr_ex_hazard, jr_mem_hazard;
  logic              irq_window, irq_take;

  assign load_use = ID_EX_MemRead && (ID_EX_InstRt != 5'd0) &&
                    ((ID_EX_InstRt == IF_ID_InstRs) || (ID_EX_InstRt == IF_ID_InstRt));

  assign jr_ex_hazard = (ID_PCSrc == PCSRC_JR) && ID_EX_MemRead &&
                        (ID_EX_InstRt != 5'd0) && (ID_EX_InstRt == IF_ID_InstRs);

  assign jr_mem_hazard = (ID_PCSrc == PCSRC_JR) && EX_MEM_MemRead &&
                         (EX_MEM_RegWriteAddr != 5'd0) && (EX_MEM_RegWriteAddr == IF_ID_InstRs);

  // A multiply/divide in flight holds the interrupt back until its final cycle.
  always_comb begin
    irq_window = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: irq_window = 1'b1;
`ifdef HAZARD_MULDIV_EN
      ST_MULDIV:        irq_window = cnt_zero;
`endif
      default:          irq_window = 1'b0;
    endcase
  end

  assign irq_take = IRQ && !irq_block_q && irq_window;

  // A level IRQ stays blocked after acceptance until it has been seen low.
  assign irq_block_d = IRQ && (irq_block_q || irq_take);

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    stall        = 1'b0;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    IRQ_Ack      = 1'b0;
    Busy         = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (irq_take) begin
          state_d = ST_IRQ_FLUSH;
`ifdef HAZARD_MULDIV_EN
        end else if (MulDiv_Start) begin
          stall        = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(MULDIV_LATENCY - 1);
          state_d      = ST_MULDIV;
`endif
        end else if (jr_ex_hazard) begin
          stall        = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(JR_EX_STALL_CYCLES - 1);
          state_d      = ST_STALL;
        end else if (jr_mem_hazard || load_use) begin
          stall = 1'b1;
        end else if (ID_PCSrc != PCSRC_SEQ) begin
          IF_ID_Flush = 1'b1;
        end
      end
      ST_STALL: begin
        stall   = 1'b1;
        cnt_dec = 1'b1;
        if (irq_take) begin
          state_d = ST_IRQ_FLUSH;
        end else if (cnt_zero) begin
          state_d = ST_RUN;
        end
      end
`ifdef HAZARD_MULDIV_EN
      ST_MULDIV: begin
        stall   = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = irq_take ? ST_IRQ_FLUSH : ST_RUN;
        end
      end
`endif
      ST_IRQ_FLUSH: begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        EX_MEM_Flush = 1'b1;
        IRQ_Ack      = 1'b1;
        Busy         = 1'b1;
        state_d      = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (stall) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      Busy        = 1'b1;
    end

    // Reset holds the pipeline frozen and full of bubbles.
    if (!reset) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
      IRQ_Ack      = 1'b0;
      Busy         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      irq_block_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_block_q <= irq_block_d;
    end
  end

  stall_counter #(.W(CNT_W)) u_stall_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

`ifndef HAZARD_MULDIV_EN
  logic unused_muldiv;
  assign unused_muldiv = MulDiv_Start ^ (MULDIV_LATENCY == 0);
`endif

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random cycles,
// each cycle compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int LAT = 4;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // Output vector order: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, IRQ_Ack, Busy
  localparam logic [6:0] V_NORMAL = 7'b1100000;
  localparam logic [6:0] V_CTRL   = 7'b1110000;
  localparam logic [6:0] V_STALL  = 7'b0001001;
  localparam logic [6:0] V_IRQF   = 7'b1111111;
  localparam logic [6:0] V_RESET  = 7'b0011100;

  logic       clk;
  logic       rst_n;
  logic       id_ex_memread;
  logic [4:0] id_ex_rt;
  logic       ex_mem_memread;
  logic [4:0] ex_mem_wa;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic [2:0] pcsrc;
  logic       irq;
  logic       muldiv;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, irq_ack, busy;
  state_e     dbg_state;

  int tests_run = 0;
  int failed    = 0;

  // Model state: forced stall cycles still owed, whether they belong to a mult/div,
  // an accepted interrupt awaiting its flush cycle, and an acknowledged IRQ level still high.
  int hold_left = 0;
  bit hold_md   = 1'b0;
  bit ack_due   = 1'b0;
  bit irq_done  = 1'b0;

  hazard_ctrl #(.MULDIV_LATENCY(LAT)) dut (
    .clk                 (clk),
    .reset               (rst_n),
    .ID_EX_MemRead       (id_ex_memread),
    .ID_EX_InstRt        (id_ex_rt),
    .EX_MEM_MemRead      (ex_mem_memread),
    .EX_MEM_RegWriteAddr (ex_mem_wa),
    .IF_ID_InstRs        (if_id_rs),
    .IF_ID_InstRt        (if_id_rt),
    .ID_PCSrc            (pcsrc),
    .IRQ                 (irq),
    .MulDiv_Start        (muldiv),
    .PC_Write            (pc_write),
    .IF_ID_Write         (if_id_write),
    .IF_ID_Flush         (if_id_flush),
    .ID_EX_Flush         (id_ex_flush),
    .EX_MEM_Flush        (ex_mem_flush),
    .IRQ_Ack             (irq_ack),
    .Busy                (busy),
    .dbg_state_o         (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(output logic [6:0] exp);
    bit eligible;
    bit took;
    bit jr;
    eligible = irq && !irq_done;
    took     = 1'b0;
    jr       = (pcsrc == 3'b011);
    if (!rst_n) begin
      exp       = V_RESET;
      hold_left = 0;
      ack_due   = 1'b0;
      irq_done  = 1'b0;
      return;
    end
    if (ack_due) begin
      exp     = V_IRQF;
      ack_due = 1'b0;
    end else if (hold_left > 0) begin
      exp       = V_STALL;
      hold_left = hold_left - 1;
      if (eligible && (!hold_md || hold_left == 0)) begin
        took      = 1'b1;
        ack_due   = 1'b1;
        hold_left = 0;
      end
    end else if (eligible) begin
      exp     = V_NORMAL;
      took    = 1'b1;
      ack_due = 1'b1;
    end else if (MD_EN && muldiv) begin
      exp       = V_STALL;
      hold_left = LAT - 1;
      hold_md   = 1'b1;
    end else if (jr && id_ex_memread && id_ex_rt != 0 && id_ex_rt == if_id_rs) begin
      exp       = V_STALL;
      hold_left = 1;
      hold_md   = 1'b0;
    end else if ((jr && ex_mem_memread && ex_mem_wa != 0 && ex_mem_wa == if_id_rs) ||
                 (id_ex_memread && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt))) begin
      exp = V_STALL;
    end else if (pcsrc != 3'b000) begin
      exp = V_CTRL;
    end else begin
      exp = V_NORMAL;
    end
    irq_done = irq && (irq_done || took);
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, irq_ack, busy};
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    rst_n          = 1'b1;
    id_ex_memread  = 1'b0;
    id_ex_rt       = 5'd0;
    ex_mem_memread = 1'b0;
    ex_mem_wa      = 5'd0;
    if_id_rs       = 5'd0;
    if_id_rt       = 5'd0;
    pcsrc          = 3'b000;
    irq            = 1'b0;
    muldiv         = 1'b0;
  endtask

  // Inputs are set at the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input string tag);
    logic [6:0] exp;
    #1;
    model_step(exp);
    chk(tag, exp);
    @(negedge clk);
  endtask

  task automatic step_d(input string tag, input logic [6:0] dir_exp);
    logic [6:0] exp;
    #1;
    model_step(exp);
    chk(tag, exp);
    chk({tag, "_dir"}, dir_exp);
    @(negedge clk);
  endtask

  task automatic set_jr_ex(input logic [4:0] r);
    clear_in();
    id_ex_memread = 1'b1;
    id_ex_rt      = r;
    if_id_rs      = r;
    pcsrc         = 3'b011;
  endtask

  task automatic set_jr_mem(input logic [4:0] r);
    clear_in();
    ex_mem_memread = 1'b1;
    ex_mem_wa      = r;
    if_id_rs       = r;
    pcsrc          = 3'b011;
  endtask

  initial begin
    clear_in();
    rst_n = 1'b0;
    @(negedge clk);
    step_d("reset0", V_RESET);
    irq = 1'b1;
    step_d("reset1_irq", V_RESET);
    clear_in();
    step_d("post_reset", V_NORMAL);

    // Load-use on Rs, then the bubble lets the consumer proceed.
    clear_in(); id_ex_memread = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    step_d("lu_rs", V_STALL);
    clear_in(); ex_mem_memread = 1'b1; ex_mem_wa = 5'd8; if_id_rs = 5'd8;
    step_d("lu_rs_after", V_NORMAL);

    clear_in(); id_ex_memread = 1'b1; id_ex_rt = 5'd12; if_id_rt = 5'd12;
    step_d("lu_rt", V_STALL);
    clear_in(); id_ex_memread = 1'b1; id_ex_rt = 5'd0;
    step_d("lu_r0", V_NORMAL);
    clear_in(); id_ex_memread = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3; pcsrc = 3'b001;
    step_d("lu_over_branch", V_STALL);

    // jr with its source loaded in EX: two stall cycles, then the jump flushes IF.
    set_jr_ex(5'd31);
    step_d("jr_ex_c1", V_STALL);
    set_jr_mem(5'd31);
    step_d("jr_ex_c2", V_STALL);
    clear_in(); if_id_rs = 5'd31; pcsrc = 3'b011;
    step_d("jr_ex_go", V_CTRL);
    clear_in();
    step_d("jr_ex_idle", V_NORMAL);

    set_jr_mem(5'd5);
    step_d("jr_mem_c1", V_STALL);
    clear_in(); if_id_rs = 5'd5; pcsrc = 3'b011;
    step_d("jr_mem_go", V_CTRL);

    clear_in(); pcsrc = 3'b001;
    step_d("branch", V_CTRL);
    clear_in(); pcsrc = 3'b010;
    step_d("jump", V_CTRL);
    clear_in();
    step_d("seq", V_NORMAL);

    // IRQ raised inside a jr stall, held five cycles: one acknowledge only.
    set_jr_ex(5'd9);
    step_d("irq_jr_c1", V_STALL);
    set_jr_mem(5'd9); irq = 1'b1;
    step_d("irq_jr_c2", V_STALL);
    clear_in(); irq = 1'b1;
    step_d("irq_flush", V_IRQF);
    for (int i = 0; i < 3; i++) begin
      clear_in(); irq = 1'b1;
      step_d("irq_held", V_NORMAL);
    end
    clear_in();
    step_d("irq_low", V_NORMAL);
    irq = 1'b1;
    step_d("irq_rearm", V_NORMAL);
    clear_in();
    step_d("irq_flush2", V_IRQF);
    step_d("irq_done", V_NORMAL);

    // Reset in the first STALL cycle abandons the stall.
    set_jr_ex(5'd4);
    step_d("rst_stall_c1", V_STALL);
    set_jr_mem(5'd4); rst_n = 1'b0;
    step_d("rst_stall_rst", V_RESET);
    clear_in();
    step_d("rst_stall_run", V_NORMAL);

`ifdef HAZARD_MULDIV_EN
    clear_in(); muldiv = 1'b1;
    step_d("md_c1", V_STALL);
    clear_in();
    step_d("md_c2", V_STALL);
    irq = 1'b1;
    step_d("md_c3_irq", V_STALL);
    step_d("md_c4_irq", V_STALL);
    clear_in();
    step_d("md_ack", V_IRQF);
    step_d("md_done", V_NORMAL);
`else
    clear_in(); muldiv = 1'b1;
    step_d("md_ignored", V_NORMAL);
    clear_in();
    step_d("md_ignored_next", V_NORMAL);
`endif

    for (int i = 0; i < 400; i++) begin
      rst_n          = ($urandom_range(0, 63) != 0);
      id_ex_memread  = 1'($urandom_range(0, 1));
      id_ex_rt       = 5'($urandom_range(0, 3));
      ex_mem_memread = 1'($urandom_range(0, 1));
      ex_mem_wa      = 5'($urandom_range(0, 3));
      if_id_rs       = 5'($urandom_range(0, 3));
      if_id_rt       = 5'($urandom_range(0, 3));
      pcsrc          = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) irq = ~irq;
      muldiv         = ($urandom_range(0, 15) == 0);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
